// File: rtl/traffic_gen_chk.sv
// traffic_gen_chk: pattern stream generator paired with a loopback checker.
// The generator drives tx_*; the checker regenerates the same pattern on its
// own and compares every returned rx beat against it, counting mismatches.
module traffic_gen_chk #(
    parameter int          DATA_W      = 64,
    parameter int          PKT_LEN     = 16,
    parameter int          NUM_PKTS    = 4,
    parameter int          MODE        = 0,
    parameter logic [31:0] SEED        = 32'h1,
    parameter int          TIMEOUT_CYC = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [15:0]       tx_pkt_cnt,
    output logic [15:0]       rx_pkt_cnt
);

    localparam int          REPS         = (DATA_W + 31) / 32;
    localparam logic [15:0] LAST_BEAT    = 16'(PKT_LEN - 1);
    localparam logic [15:0] LAST_PKT     = 16'(NUM_PKTS - 1);
    localparam logic [31:0] LAST_TX_BEAT = 32'(longint'(NUM_PKTS) * longint'(PKT_LEN) - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [31:0]       tx_beat_cnt;
    logic [15:0]       tx_idx;
    logic [15:0]       rx_idx;
    logic [DATA_W-1:0] tx_inc;
    logic [DATA_W-1:0] rx_inc;
    logic [31:0]       tx_lfsr;
    logic [31:0]       rx_lfsr;
    logic [23:0]       idle_cnt;

    logic              tx_hs;
    logic              rx_hs;
    logic [DATA_W-1:0] exp_data;
    logic              exp_last;
    logic              beat_err;
    logic [15:0]       err_next;
    logic              final_rx;
    logic              idle_expired;

    // Fibonacci LFSR, taps 32,22,2,1; new bit enters at the bottom.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Beat payload: either the running beat index or the LFSR word tiled across the bus.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] inc,
                                                  input logic [31:0]       lfsr);
        logic [REPS*32-1:0] rep;
        rep = {REPS{lfsr}};
        return (MODE == 0) ? inc : rep[DATA_W-1:0];
    endfunction

    // Handshakes, the checker's expected beat, and the run-ending conditions.
    always_comb begin
        tx_hs        = tx_valid && tx_ready;
        rx_hs        = rx_valid && rx_ready;
        exp_data     = pattern(rx_inc, rx_lfsr);
        exp_last     = (rx_idx == LAST_BEAT);
        beat_err     = rx_hs && ((rx_data != exp_data) || (rx_last != exp_last));
        err_next     = (beat_err && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
        final_rx     = rx_hs && exp_last && (rx_pkt_cnt == LAST_PKT);
        idle_expired = !rx_hs && (idle_cnt == TIMEOUT_LAST);
    end

    // The generator state only moves on a handshake, so the payload holds through stalls;
    // gating with tx_valid keeps the bus at zero outside an active run.
    assign tx_data = tx_valid ? pattern(tx_inc, tx_lfsr) : '0;
    assign tx_last = tx_valid && (tx_idx == LAST_BEAT);

    // Run control FSM together with the generator, checker and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            rx_ready    <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            tx_pkt_cnt  <= '0;
            rx_pkt_cnt  <= '0;
            tx_beat_cnt <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            tx_inc      <= '0;
            rx_inc      <= '0;
            tx_lfsr     <= SEED;
            rx_lfsr     <= SEED;
            idle_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        tx_valid    <= 1'b1;
                        rx_ready    <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        err_cnt     <= '0;
                        tx_pkt_cnt  <= '0;
                        rx_pkt_cnt  <= '0;
                        tx_beat_cnt <= '0;
                        tx_idx      <= '0;
                        rx_idx      <= '0;
                        tx_inc      <= '0;
                        rx_inc      <= '0;
                        tx_lfsr     <= SEED;
                        rx_lfsr     <= SEED;
                        idle_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (tx_hs) begin
                        tx_inc      <= tx_inc + DATA_W'(1);
                        tx_lfsr     <= lfsr_next(tx_lfsr);
                        tx_beat_cnt <= tx_beat_cnt + 32'd1;
                        if (tx_last) begin
                            tx_idx     <= '0;
                            tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
                        end else begin
                            tx_idx <= tx_idx + 16'd1;
                        end
                        if (tx_beat_cnt == LAST_TX_BEAT) begin
                            tx_valid <= 1'b0;
                        end
                    end
                    if (rx_hs) begin
                        rx_inc   <= rx_inc + DATA_W'(1);
                        rx_lfsr  <= lfsr_next(rx_lfsr);
                        err_cnt  <= err_next;
                        idle_cnt <= '0;
                        if (exp_last) begin
                            rx_idx     <= '0;
                            rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
                        end else begin
                            rx_idx <= rx_idx + 16'd1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 24'd1;
                    end
                    if (final_rx) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        pass     <= (err_next == 16'd0);
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b0;
                    end else if (idle_expired) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        pass     <= 1'b0;
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_gen_chk.sv
// tb_traffic_gen_chk: drives two traffic_gen_chk instances (incrementing and LFSR
// patterns) through looped-back runs with directed and random flow control, and
// compares every accepted beat and the final status against a reference model.
module tb_traffic_gen_chk;

    localparam int          DATA_W      = 64;
    localparam int          PKT_LEN     = 4;
    localparam int          NUM_PKTS    = 2;
    localparam int          TIMEOUT_CYC = 100;
    localparam logic [31:0] SEED        = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a    [2];
    logic        tx_ready_a [2];
    logic        rx_valid_a [2];
    logic [63:0] rx_data_a  [2];
    logic        rx_last_a  [2];
    logic        tx_valid_a [2];
    logic [63:0] tx_data_a  [2];
    logic        tx_last_a  [2];
    logic        rx_ready_a [2];
    logic        done_a     [2];
    logic        pass_a     [2];
    logic        timeout_a  [2];
    logic [15:0] err_a      [2];
    logic [15:0] txp_a      [2];
    logic [15:0] rxp_a      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_gen_chk #(
        .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
        .MODE(0), .SEED(SEED), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut_inc (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]),
        .tx_valid(tx_valid_a[0]), .tx_data(tx_data_a[0]), .tx_last(tx_last_a[0]),
        .tx_ready(tx_ready_a[0]),
        .rx_valid(rx_valid_a[0]), .rx_data(rx_data_a[0]), .rx_last(rx_last_a[0]),
        .rx_ready(rx_ready_a[0]),
        .done(done_a[0]), .pass(pass_a[0]), .timeout(timeout_a[0]),
        .err_cnt(err_a[0]), .tx_pkt_cnt(txp_a[0]), .rx_pkt_cnt(rxp_a[0])
    );

    traffic_gen_chk #(
        .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
        .MODE(1), .SEED(SEED), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut_lfsr (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]),
        .tx_valid(tx_valid_a[1]), .tx_data(tx_data_a[1]), .tx_last(tx_last_a[1]),
        .tx_ready(tx_ready_a[1]),
        .rx_valid(rx_valid_a[1]), .rx_data(rx_data_a[1]), .rx_last(rx_last_a[1]),
        .rx_ready(rx_ready_a[1]),
        .done(done_a[1]), .pass(pass_a[1]), .timeout(timeout_a[1]),
        .err_cnt(err_a[1]), .tx_pkt_cnt(txp_a[1]), .rx_pkt_cnt(rxp_a[1])
    );

    // Reference LFSR step: shift left, new bit is the parity of tap bits 32,22,2,1.
    function automatic logic [31:0] model_lfsr_step(input logic [31:0] v);
        return {v[30:0], ^(v & 32'h8020_0003)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Every output of one instance must be zero (reset / idle state).
    task automatic checkIdle(input logic sel, input string tag);
        checkFlag({tag, "_tx_valid"}, tx_valid_a[sel], 1'b0);
        checkOutput({tag, "_tx_data"}, tx_data_a[sel], 64'd0);
        checkFlag({tag, "_tx_last"}, tx_last_a[sel], 1'b0);
        checkFlag({tag, "_rx_ready"}, rx_ready_a[sel], 1'b0);
        checkFlag({tag, "_done"}, done_a[sel], 1'b0);
        checkFlag({tag, "_pass"}, pass_a[sel], 1'b0);
        checkFlag({tag, "_timeout"}, timeout_a[sel], 1'b0);
        checkOutput({tag, "_err_cnt"}, 64'(err_a[sel]), 64'd0);
        checkOutput({tag, "_tx_pkt_cnt"}, 64'(txp_a[sel]), 64'd0);
        checkOutput({tag, "_rx_pkt_cnt"}, 64'(rxp_a[sel]), 64'd0);
    endtask

    // One run on instance sel with tx looped back to rx through a queue.
    // ready_mode: 0 always ready, 1 toggling 1,0, 2 random.  rx_mode: 0 return
    // beats as soon as queued, 1 random gaps.  corrupt_beat flips bit 0 of that
    // returned beat (-1 none).  restart_at pulses start during RUN on that cycle
    // (-1 none).  stop_tx > 0 abandons the run after that many accepted tx beats.
    task automatic applyStimulus(input logic sel, input int ready_mode, input int rx_mode,
                                 input int corrupt_beat, input int restart_at,
                                 input int stop_tx);
        logic [63:0] q_data[$];
        logic        q_last[$];
        int          k;
        int          rx_k;
        int          n_corrupt;
        logic [31:0] lfsr;
        logic        tr;
        logic        stalled;
        logic [63:0] stall_data;
        logic        stall_last;
        logic [63:0] exp_data;
        logic        exp_last;

        k          = 0;
        rx_k       = 0;
        n_corrupt  = 0;
        lfsr       = SEED;
        stalled    = 1'b0;
        stall_data = 64'd0;
        stall_last = 1'b0;

        @(negedge clk);
        start_a[sel]    = 1'b1;
        tx_ready_a[sel] = 1'b0;
        rx_valid_a[sel] = 1'b0;
        @(negedge clk);
        start_a[sel] = 1'b0;
        checkFlag("first_tx_valid", tx_valid_a[sel], 1'b1);
        checkOutput("first_tx_data", tx_data_a[sel], (sel == 1'b0) ? 64'd0 : {SEED, SEED});
        checkFlag("run_rx_ready", rx_ready_a[sel], 1'b1);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done_a[sel]) break;

            if (stalled) begin
                checkFlag("stall_valid", tx_valid_a[sel], 1'b1);
                checkOutput("stall_data", tx_data_a[sel], stall_data);
                checkFlag("stall_last", tx_last_a[sel], stall_last);
            end

            start_a[sel] = (cyc == restart_at);
            case (ready_mode)
                0:       tr = 1'b1;
                1:       tr = (cyc % 2 == 0);
                default: tr = ($urandom_range(0, 1) == 1);
            endcase
            tx_ready_a[sel] = tr;

            if (q_data.size() > 0 && (rx_mode == 0 || $urandom_range(0, 1) == 1)) begin
                rx_valid_a[sel] = 1'b1;
                rx_data_a[sel]  = q_data[0] ^ ((rx_k == corrupt_beat) ? 64'd1 : 64'd0);
                rx_last_a[sel]  = q_last[0];
            end else begin
                rx_valid_a[sel] = 1'b0;
                rx_data_a[sel]  = 64'd0;
                rx_last_a[sel]  = 1'b0;
            end

            if (rx_valid_a[sel] && rx_ready_a[sel]) begin
                if (rx_k == corrupt_beat) n_corrupt++;
                q_data.delete(0);
                q_last.delete(0);
                rx_k++;
            end

            stalled    = tx_valid_a[sel] && !tr;
            stall_data = tx_data_a[sel];
            stall_last = tx_last_a[sel];

            if (tx_valid_a[sel] && tr) begin
                exp_data = (sel == 1'b0) ? 64'(k) : {lfsr, lfsr};
                exp_last = ((k % PKT_LEN) == PKT_LEN - 1);
                checkOutput("tx_data", tx_data_a[sel], exp_data);
                checkFlag("tx_last", tx_last_a[sel], exp_last);
                q_data.push_back(tx_data_a[sel]);
                q_last.push_back(tx_last_a[sel]);
                k++;
                lfsr = model_lfsr_step(lfsr);
                if (k == stop_tx) break;
            end
        end

        if (stop_tx != 0) begin
            @(posedge clk);
            #1;
        end
        start_a[sel]    = 1'b0;
        tx_ready_a[sel] = 1'b0;
        rx_valid_a[sel] = 1'b0;
        rx_data_a[sel]  = 64'd0;
        rx_last_a[sel]  = 1'b0;

        if (stop_tx == 0) begin
            checkFlag("run_done", done_a[sel], 1'b1);
            checkFlag("run_pass", pass_a[sel], n_corrupt == 0);
            checkFlag("run_timeout", timeout_a[sel], 1'b0);
            checkOutput("run_err_cnt", 64'(err_a[sel]), 64'(n_corrupt));
            checkOutput("run_rx_pkt_cnt", 64'(rxp_a[sel]), 64'(NUM_PKTS));
            checkOutput("run_tx_pkt_cnt", 64'(txp_a[sel]), 64'(NUM_PKTS));
            checkOutput("run_tx_beats", 64'(k), 64'(NUM_PKTS * PKT_LEN));
            checkFlag("run_tx_valid_low", tx_valid_a[sel], 1'b0);
            checkFlag("run_rx_ready_low", rx_ready_a[sel], 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_a[s]    = 1'b0;
            tx_ready_a[s] = 1'b0;
            rx_valid_a[s] = 1'b0;
            rx_data_a[s]  = 64'd0;
            rx_last_a[s]  = 1'b0;
        end

        #12;
        checkIdle(1'b0, "reset_inc");
        checkIdle(1'b1, "reset_lfsr");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] loopback runs, incrementing pattern");
        applyStimulus(1'b0, 0, 0, -1, -1, 0);
        applyStimulus(1'b0, 1, 0, -1, -1, 0);
        applyStimulus(1'b0, 0, 0, 5, -1, 0);
        applyStimulus(1'b0, 2, 1, -1, 3, 0);
        applyStimulus(1'b0, 2, 1, 2, -1, 0);

        $display("[TB] rx silent, expecting abort after %0d cycles", TIMEOUT_CYC);
        @(negedge clk);
        start_a[0]    = 1'b1;
        tx_ready_a[0] = 1'b1;
        rx_valid_a[0] = 1'b0;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        checkFlag("timeout_not_early", done_a[0], 1'b0);
        @(negedge clk);
        checkFlag("timeout_done", done_a[0], 1'b1);
        checkFlag("timeout_flag", timeout_a[0], 1'b1);
        checkFlag("timeout_pass", pass_a[0], 1'b0);
        checkOutput("timeout_rx_pkt_cnt", 64'(rxp_a[0]), 64'd0);
        checkOutput("timeout_tx_pkt_cnt", 64'(txp_a[0]), 64'(NUM_PKTS));
        checkFlag("timeout_rx_ready", rx_ready_a[0], 1'b0);
        tx_ready_a[0] = 1'b0;

        $display("[TB] loopback runs, LFSR pattern");
        applyStimulus(1'b1, 0, 0, -1, -1, 0);
        applyStimulus(1'b1, 2, 1, -1, -1, 0);

        $display("[TB] reset in the middle of a run");
        applyStimulus(1'b0, 0, 0, -1, -1, 4);
        checkOutput("pre_reset_tx_pkt_cnt", 64'(txp_a[0]), 64'd1);
        checkFlag("pre_reset_tx_valid", tx_valid_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        checkIdle(1'b0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkFlag("no_resume_tx_valid", tx_valid_a[0], 1'b0);
        checkFlag("no_resume_rx_ready", rx_ready_a[0], 1'b0);
        applyStimulus(1'b0, 0, 0, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_gen_chk.md
TRAFFIC_GEN_CHK -- requirements
Module: traffic_gen_chk

Interface
REQ-001 Parameter DATA_W, default 64, meaning stream data width in bits (legal 8..512, multiple of 8).
REQ-002 Parameter PKT_LEN, default 16, meaning beats per packet (legal 1..65535).
REQ-003 Parameter NUM_PKTS, default 4, meaning packets per run (legal 1..65535).
REQ-004 Parameter MODE, default 0, meaning pattern select (0 = incrementing, 1 = LFSR).
REQ-005 Parameter SEED, default 32'h1, meaning LFSR seed (nonzero).
REQ-006 Parameter TIMEOUT_CYC, default 10000, meaning idle-rx cycles before abort (legal 1..2^24-1).
REQ-007 clk  in  1  sole clock; all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  single-cycle run request.
REQ-010 tx_valid / tx_data / tx_last  out  1 / DATA_W / 1  generated stream.
REQ-011 tx_ready  in  1  downstream accept.
REQ-012 rx_valid / rx_data / rx_last  in  1 / DATA_W / 1  returned stream.
REQ-013 rx_ready  out  1  checker accept.
REQ-014 done / pass / timeout  out  1 / 1 / 1  run status.
REQ-015 err_cnt  out  16  mismatched-beat count.
REQ-016 tx_pkt_cnt / rx_pkt_cnt  out  16 / 16  completed packets sent / received.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when rx_pkt_cnt reaches NUM_PKTS or on timeout; DONE->RUN on start.
REQ-018 Every entry into RUN clears all counters, done, pass, timeout and both pattern generators in the same edge.
REQ-019 start in RUN is ignored.
REQ-020 Handshake on a channel = valid && ready at a rising edge; a beat advances only on a handshake.
REQ-021 tx_valid is high in RUN until NUM_PKTS*PKT_LEN beats are accepted, low otherwise; tx_data/tx_last stay stable while tx_valid && !tx_ready.
REQ-022 First tx_valid beat appears the cycle after the start edge (1-cycle latency).
REQ-023 tx_last is high on beat PKT_LEN-1 of each packet; tx_pkt_cnt increments on each tx_last handshake.
REQ-024 MODE 0: beat k (k from 0 across the run) carries k zero-extended to DATA_W, wrapping mod 2^DATA_W.
REQ-025 MODE 1: 32-bit Fibonacci LFSR, taps 32,22,2,1, starts at SEED, steps once per handshake; tx_data = LFSR value replicated, truncated to DATA_W.
REQ-026 Checker holds an independent copy of the generator advanced only on rx handshakes; expected last = beat PKT_LEN-1 of packet.
REQ-027 rx_ready is high in RUN, low in IDLE and DONE.
REQ-028 A rx beat mismatching in data or last increments err_cnt by one, saturating at 16'hFFFF.
REQ-029 rx_pkt_cnt increments on each rx handshake whose expected last is high, regardless of mismatch.
REQ-030 Timeout counter increments each RUN cycle without rx handshake, clears on rx handshake; reaching TIMEOUT_CYC sets timeout and enters DONE.
REQ-031 done is high in DONE only; pass = done && !timeout && err_cnt==0, registered with done.
REQ-032 Simultaneous final rx handshake and timeout expiry: handshake wins, timeout stays 0.
REQ-033 tx and rx handshakes in the same cycle are independent; both apply.

Reset
REQ-034 rst_n low forces IDLE, all outputs 0 immediately, generators to initial value, regardless of state.
REQ-035 Deassertion mid-run leaves block in IDLE; no resumption without a new start.

Verification
REQ-036 Loopback tx->rx, tx_ready=1, MODE 0, PKT_LEN=4, NUM_PKTS=2, start -> data 0..7, tx_last on beats 3 and 7, done=1, pass=1, err_cnt=0, rx_pkt_cnt=2.
REQ-037 Same, tx_ready toggling 1,0 each cycle -> tx_data stable during stalls, same final results as REQ-036.
REQ-038 Loopback, rx_data bit 0 inverted on beat 5 -> err_cnt=1, pass=0, done=1, rx_pkt_cnt=2.
REQ-039 rx_valid tied 0, TIMEOUT_CYC=100 -> done and timeout at 100 cycles after start, pass=0, rx_pkt_cnt=0.
REQ-040 MODE 1, SEED=1, DATA_W=64 -> first tx_data 64'h0000000100000001; loopback pass=1.
REQ-041 rst_n pulsed low after beat 3 of REQ-036 -> all outputs 0 at once; new start reproduces REQ-036 from data 0.
